// File: rtl/traffic_pkg.sv
// Shared types for the parametrised traffic-light controller: FSM state
// encoding and the {R,Y,G} lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    AR1    = 3'd2,
    WALK   = 3'd3,
    SIDE_G = 3'd4,
    SIDE_Y = 3'd5,
    AR2    = 3'd6
  } state_t;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: tick is high on the last clock of each TICK_DIV-cycle
// window. clr restarts the window so intervals align to state changes.
module sec_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;

  assign tick = (prescaler == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              prescaler <= '0;
    else if (clr || tick)   prescaler <= '0;
    else                    prescaler <= prescaler + 1'b1;
  end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Main/side/pedestrian traffic controller with configurable second-based
// timing, sensor-driven green extensions and optional all-red clearance.
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int T_BASE   = 6,
  parameter int T_EXT    = 3,
  parameter int MAX_EXT  = 1,
  parameter int T_YEL    = 2,
  parameter int T_WALK   = 3,
  parameter int T_ALLRED = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       button_walk,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic       light_walk,
  output logic       walk_pending
);

  localparam int M1   = (T_BASE > T_EXT) ? T_BASE : T_EXT;
  localparam int M2   = (M1 > T_YEL) ? M1 : T_YEL;
  localparam int M3   = (M2 > T_WALK) ? M2 : T_WALK;
  localparam int MAXD = (M3 > T_ALLRED) ? M3 : T_ALLRED;
  localparam int SW   = $clog2(MAXD + 1);
  localparam int EW   = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

  state_t          state, state_nxt;
  logic [SW-1:0]   sec_cnt, dur;
  logic [EW-1:0]   ext_cnt;
  logic            tick, iv_end, is_green, extend;

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (iv_end),
    .tick  (tick)
  );

  always_comb begin
    dur = SW'(T_BASE);
    case (state)
      MAIN_G, SIDE_G: dur = (ext_cnt == '0) ? SW'(T_BASE) : SW'(T_EXT);
      MAIN_Y, SIDE_Y: dur = SW'(T_YEL);
      WALK:           dur = SW'(T_WALK);
      AR1, AR2:       dur = SW'(T_ALLRED);
      default:        dur = SW'(T_BASE);
    endcase
  end

  // Every interval end either changes state or starts an extension, so it
  // is also the timebase clear.
  assign iv_end   = tick && (sec_cnt == dur - SW'(1));
  assign is_green = (state == MAIN_G) || (state == SIDE_G);
  assign extend   = iv_end && is_green && sensor && (ext_cnt < EW'(MAX_EXT));

  always_comb begin
    state_nxt = state;
    if (iv_end && !extend) begin
      case (state)
        MAIN_G:  state_nxt = MAIN_Y;
        MAIN_Y:  state_nxt = (T_ALLRED != 0) ? AR1 : (walk_pending ? WALK : SIDE_G);
        AR1:     state_nxt = walk_pending ? WALK : SIDE_G;
        WALK:    state_nxt = SIDE_G;
        SIDE_G:  state_nxt = SIDE_Y;
        SIDE_Y:  state_nxt = (T_ALLRED != 0) ? AR2 : MAIN_G;
        AR2:     state_nxt = MAIN_G;
        default: state_nxt = MAIN_G;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= MAIN_G;
      sec_cnt      <= '0;
      ext_cnt      <= '0;
      walk_pending <= 1'b0;
    end else begin
      state <= state_nxt;

      if (iv_end)    sec_cnt <= '0;
      else if (tick) sec_cnt <= sec_cnt + 1'b1;

      if (extend)      ext_cnt <= ext_cnt + 1'b1;
      else if (iv_end) ext_cnt <= '0;

      // Entering WALK serves the request and beats a simultaneous press.
      if (iv_end && state_nxt == WALK)             walk_pending <= 1'b0;
      else if (button_walk && state != WALK)       walk_pending <= 1'b1;
    end
  end

  always_comb begin
    light_main = LIGHT_R;
    light_side = LIGHT_R;
    light_walk = 1'b0;
    case (state)
      MAIN_G:  light_main = LIGHT_G;
      MAIN_Y:  light_main = LIGHT_Y;
      SIDE_G:  light_side = LIGHT_G;
      SIDE_Y:  light_side = LIGHT_Y;
      WALK:    light_walk = 1'b1;
      default: ;
    endcase
  end

endmodule
